pkt_dmux_n: RTL

- Parametrised packet demultiplexer for the 134-bit pipeline packet bus.
- Sits between the FPGA OS packet input and N downstream processing modules, e.g. PGM, LCM, SSM and spares.
- Routes each packet to one channel, selected by a configurable field in the head word.
- Drops packets with an out-of-range selector or a busy destination, truncates over-length packets, and counts drops and protocol errors.

---
 rtl/pkt_dmux_n.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pkt_dmux_n.sv
// ---------------------------------------------------------------------------
// pkt_dmux_n -- packet demultiplexer for the pipeline packet bus.
//
// Routes each packet to one of NCH downstream channels. The channel is taken
// from a selector field in the head word. A packet is dropped when its
// selector is out of range or its destination is not ready at the head.
// Over-length packets are cut with a forced tail. Dropped packets and
// framing errors are counted in saturating counters.
//
// Framing tag, pktin_data[DW-1:DW-2]: 01 head, 11 body, 10 tail, 00 illegal.
//
// Ports
//   clk                  system clock
//   rst_n                asynchronous active-low reset
//   pktin_data           input packet word
//   pktin_data_wr        input word strobe
//   pktin_data_valid     input packet metadata (valid with its strobe)
//   pktin_data_valid_wr  input metadata strobe, issued with the tail
//   out_ready            per channel: room for one MAX_LEN packet
//   out_data             registered data word, broadcast to all channels
//   out_data_wr          per-channel word strobe
//   out_data_valid       registered metadata bit, broadcast
//   out_data_valid_wr    per-channel metadata strobe
//   cur_ch               channel of the packet in flight, 0 when idle
//   drop_cnt             saturating count of dropped packets
//   err_cnt              saturating count of protocol errors
// ---------------------------------------------------------------------------
module pkt_dmux_n #(
  parameter int DW      = 134,
  parameter int NCH     = 4,
  parameter int SEL_LSB = 109,
  parameter int SEL_W   = 3,
  parameter int MAX_LEN = 64,
  parameter int CW      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    pktin_data,
  input  logic             pktin_data_wr,
  input  logic             pktin_data_valid,
  input  logic             pktin_data_valid_wr,
  input  logic [NCH-1:0]   out_ready,
  output logic [DW-1:0]    out_data,
  output logic [NCH-1:0]   out_data_wr,
  output logic             out_data_valid,
  output logic [NCH-1:0]   out_data_valid_wr,
  output logic [3:0]       cur_ch,
  output logic [CW-1:0]    drop_cnt,
  output logic [CW-1:0]    err_cnt
);

  localparam int LW = $clog2(MAX_LEN + 1);

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_BODY = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [LW-1:0]   wcnt;
  logic [LW-1:0]   wcnt_nxt;
  logic [3:0]      ch_nxt;

  logic [1:0]      tag;
  logic [SEL_W-1:0] sel;
  logic            head_ok;

  logic            fwd_en;
  logic [3:0]      fwd_ch;
  logic [DW-1:0]   fwd_word;
  logic            fwd_valid;
  logic            fwd_vwr;
  logic            drop_inc;
  logic            err_inc;

  assign tag = pktin_data[DW-1 -: 2];
  assign sel = pktin_data[SEL_LSB +: SEL_W];

  // A head is accepted only for an in-range selector whose channel is ready.
  // Comparing in 32 bits keeps selectors wider than the channel index from
  // aliasing onto a valid channel.
  always_comb begin
    head_ok = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (32'(sel) == i && out_ready[i]) head_ok = 1'b1;
    end
  end

  // Next-state and datapath decode.
  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    ch_nxt    = cur_ch;
    fwd_en    = 1'b0;
    fwd_ch    = cur_ch;
    fwd_word  = pktin_data;
    fwd_valid = pktin_data_valid;
    fwd_vwr   = pktin_data_valid_wr;
    drop_inc  = 1'b0;
    err_inc   = 1'b0;

    if (pktin_data_wr) begin
      if (tag == TAG_HEAD) begin
        // A head outside IDLE abandons the current packet (no tail) and is
        // then judged exactly as a head arriving in IDLE.
        err_inc = (state != IDLE);
        if (head_ok) begin
          fwd_en    = 1'b1;
          fwd_ch    = 4'(sel);
          ch_nxt    = 4'(sel);
          wcnt_nxt  = LW'(1);
          state_nxt = FWD;
        end else begin
          drop_inc  = 1'b1;
          ch_nxt    = 4'd0;
          state_nxt = DROP;
        end
      end else begin
        case (state)
          IDLE: err_inc = 1'b1;
          DROP: begin
            if (tag == TAG_TAIL) state_nxt = IDLE;
          end
          FWD: begin
            if (tag == TAG_TAIL) begin
              fwd_en    = 1'b1;
              ch_nxt    = 4'd0;
              state_nxt = IDLE;
            end else if (tag == TAG_BODY) begin
              fwd_en = 1'b1;
              if (wcnt == LW'(MAX_LEN - 1)) begin
                // Last slot and still no tail: close the packet downstream
                // with a forced tail marked invalid, swallow the rest.
                fwd_word[DW-1 -: 2] = TAG_TAIL;
                fwd_valid           = 1'b0;
                fwd_vwr             = 1'b1;
                err_inc             = 1'b1;
                ch_nxt              = 4'd0;
                state_nxt           = DROP;
              end else begin
                wcnt_nxt = wcnt + LW'(1);
              end
            end else begin
              err_inc = 1'b1;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // reset, so an abort mid-packet clears every output at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      wcnt              <= '0;
      cur_ch            <= '0;
      out_data          <= '0;
      out_data_wr       <= '0;
      out_data_valid    <= 1'b0;
      out_data_valid_wr <= '0;
      drop_cnt          <= '0;
      err_cnt           <= '0;
    end else begin
      state             <= state_nxt;
      wcnt              <= wcnt_nxt;
      cur_ch            <= ch_nxt;
      out_data_wr       <= '0;
      out_data_valid_wr <= '0;
      if (fwd_en) begin
        out_data          <= fwd_word;
        out_data_valid    <= fwd_valid;
        out_data_wr       <= NCH'(1) << fwd_ch;
        out_data_valid_wr <= fwd_vwr ? (NCH'(1) << fwd_ch) : '0;
      end
      if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + CW'(1);
      if (err_inc && err_cnt != '1)   err_cnt  <= err_cnt + CW'(1);
    end
  end

endmodule
